// File: rtl/max_pool_window_gen_pkg.sv
// Shared types and default geometry for the max-pool window generator
// and the max-pool reduction stage that consumes its windows.
package max_pool_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_KERNEL_DIM = 3;
    localparam int DEFAULT_ROW_SIZE   = 540;
    localparam int DEFAULT_FRAME_ROWS = 540;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] pixel_t;

    // Element [i][j] sits at bits (i*KERNEL_DIM+j)*DATA_WIDTH upward.
    typedef pixel_t [DEFAULT_KERNEL_DIM-1:0][DEFAULT_KERNEL_DIM-1:0] window_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } state_t;

endpackage

// File: rtl/max_pool_window_gen_if.sv
// Pixel-in / window-out handshake bundle of the window generator.
// The slave modport is the generator itself; master is its environment.
interface max_pool_window_gen_if
    import max_pool_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int KERNEL_DIM = DEFAULT_KERNEL_DIM
);

    logic [DATA_WIDTH-1:0]                       in_pixel;
    logic                                        in_valid;
    logic                                        in_sof;
    logic                                        in_ready;
    logic [KERNEL_DIM*KERNEL_DIM*DATA_WIDTH-1:0] out_window;
    logic                                        out_valid;
    logic                                        out_ready;
    logic                                        out_last;

    modport slave (
        input  in_pixel,
        input  in_valid,
        input  in_sof,
        output in_ready,
        output out_window,
        output out_valid,
        input  out_ready,
        output out_last
    );

    modport master (
        output in_pixel,
        output in_valid,
        output in_sof,
        input  in_ready,
        input  out_window,
        input  out_valid,
        output out_ready,
        input  out_last
    );

endinterface

// File: rtl/max_pool_window_gen_line_buffer.sv
// Enable-gated delay line: while en is high, dout shows the din value
// presented DEPTH enables earlier. The output register is one stage of
// the delay, so the RAM holds DEPTH-1 entries behind a circular pointer.
module line_buffer
    import max_pool_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_ROW_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int MEM_DEPTH = DEPTH - 1;
    localparam int PW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(MEM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] dout_reg;
    logic [PW-1:0]         ptr_reg;

    // Circular pointer; contents need no reset because the delay is
    // defined purely by the number of enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (en) begin
            ptr_reg <= (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;
        end
    end

    // Read-before-write RAM access with registered read data.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_reg] <= din;
            dout_reg     <= mem[ptr_reg];
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/max_pool_window_gen.sv
// Sliding KERNEL_DIM x KERNEL_DIM window generator for a raster pixel
// stream. Emits every fully in-frame window (stride 1, no padding)
// through a single output register.
module max_pool_window_gen
    import max_pool_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int KERNEL_DIM = DEFAULT_KERNEL_DIM,
    parameter int ROW_SIZE   = DEFAULT_ROW_SIZE,
    parameter int FRAME_ROWS = DEFAULT_FRAME_ROWS
) (
    input logic                 clk,
    input logic                 rst,
    max_pool_window_gen_if.slave bus
);

    localparam int CW = $clog2(ROW_SIZE);
    localparam int RW = $clog2(FRAME_ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(KERNEL_DIM - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_ROWS - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(KERNEL_DIM - 1);

    typedef logic [DATA_WIDTH-1:0] pix_t;
    typedef pix_t [KERNEL_DIM-1:0][KERNEL_DIM-1:0] win_t;

    state_t        state_reg, state_next, eff_state;
    logic [CW-1:0] col_reg, col_next, pix_col;
    logic [RW-1:0] row_reg, row_next, pix_row;
    logic          take, emit, emit_last, in_ready;
    win_t          win_reg, win_next, out_window_reg;
    logic          out_valid_reg, out_last_reg;
    pix_t          lb_in  [KERNEL_DIM-1];
    pix_t          lb_out [KERNEL_DIM-1];

    // Pixels taken while IDLE never produce a window, so IDLE can always
    // accept without risking the pending output.
    assign in_ready = (state_reg == IDLE) || !out_valid_reg || bus.out_ready;

    assign bus.in_ready   = in_ready;
    assign bus.out_window = out_window_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_last   = out_last_reg;

    // Cascaded line buffers: buffer gi outputs the row gi+1 rows above.
    genvar gi;
    generate
        for (gi = 0; gi < KERNEL_DIM - 1; gi++) begin : g_lb
            if (gi == 0) begin : g_head
                assign lb_in[gi] = bus.in_pixel;
            end else begin : g_tail
                assign lb_in[gi] = lb_out[gi-1];
            end
            line_buffer #(
                .DATA_WIDTH(DATA_WIDTH),
                .DEPTH     (ROW_SIZE)
            ) u_lb (
                .clk (clk),
                .rst (rst),
                .en  (take),
                .din (lb_in[gi]),
                .dout(lb_out[gi])
            );
        end
    endgenerate

    // Next state, raster position and emit decision for the pixel on the bus.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        emit       = 1'b0;
        emit_last  = 1'b0;
        take       = bus.in_valid && in_ready && ((state_reg != IDLE) || bus.in_sof);
        // A start-of-frame pixel always restarts at (0,0), whatever the state.
        eff_state  = bus.in_sof ? FILL : state_reg;
        pix_col    = bus.in_sof ? '0 : col_reg;
        pix_row    = bus.in_sof ? '0 : row_reg;
        if (take) begin
            emit      = (eff_state == STREAM) && (pix_col >= COL_WIN);
            emit_last = emit && (pix_col == COL_LAST) && (pix_row == ROW_LAST);
            if ((pix_col == COL_LAST) && (pix_row == ROW_LAST)) begin
                state_next = IDLE;
                col_next   = '0;
                row_next   = '0;
            end else if (pix_col == COL_LAST) begin
                col_next   = '0;
                row_next   = pix_row + 1'b1;
                state_next = (row_next >= ROW_WIN) ? STREAM : FILL;
            end else begin
                col_next   = pix_col + 1'b1;
                row_next   = pix_row;
                state_next = eff_state;
            end
        end
    end

    // Shift the window left and load the new right column.
    always_comb begin
        win_next = win_reg;
        for (int i = 0; i < KERNEL_DIM; i++) begin
            for (int j = 0; j < KERNEL_DIM - 1; j++) begin
                win_next[i][j] = win_reg[i][j+1];
            end
        end
        for (int i = 0; i < KERNEL_DIM - 1; i++) begin
            win_next[i][KERNEL_DIM-1] = lb_out[KERNEL_DIM-2-i];
        end
        win_next[KERNEL_DIM-1][KERNEL_DIM-1] = bus.in_pixel;
    end

    // State and raster counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
        end
    end

    // Window shift register and the single output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_reg        <= '0;
            out_window_reg <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
        end else begin
            if (take) begin
                win_reg <= win_next;
            end
            if (emit) begin
                out_window_reg <= win_next;
                out_valid_reg  <= 1'b1;
                out_last_reg   <= emit_last;
            end else if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/max_pool_window_gen.md
Name: max_pool_window_gen

Overview:
- Upstream neighbour of the 3x3 max-pooling stage.
- Accepts a raster-order pixel stream (one pixel per cycle max) and buffers KERNEL_DIM-1 previous rows in line buffers.
- Emits every fully in-frame KERNEL_DIM x KERNEL_DIM window (stride 1, no padding) on a valid/ready interface, ready for the max reduction.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- KERNEL_DIM, 3, window height and width (>= 2).
- ROW_SIZE, 540, pixels per row (> KERNEL_DIM).
- FRAME_ROWS, 540, rows per frame (>= KERNEL_DIM).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_pixel  input  DATA_WIDTH  incoming pixel.
- in_valid  input  1  in_pixel is valid.
- in_sof  input  1  qualifies in_pixel as pixel (0,0) of a new frame.
- in_ready  output  1  block accepts in_pixel this cycle.
- out_window  output  KERNEL_DIM*KERNEL_DIM*DATA_WIDTH  flattened window; element [i][j] at bits (i*KERNEL_DIM+j)*DATA_WIDTH upward.
- out_valid  output  1  out_window holds a complete window.
- out_ready  input  1  downstream consumes the window.
- out_last  output  1  window is the last of the frame.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_last=0, out_window=0.
  - Window registers, row/col counters and state cleared; state=IDLE.
  - Line-buffer contents need not be cleared.
- Handshake:
  - Input accept = in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output register, no skid).
  - Output transfer = out_valid && out_ready.
  - out_window and out_last hold stable while out_valid && !out_ready.
- Window orientation:
  - Row 0 is the oldest buffered row; row KERNEL_DIM-1 is the current row.
  - Column 0 is leftmost (oldest); [K-1][K-1] is the pixel just accepted.
- On each accept:
  - The window shifts left one column.
  - The new right column is loaded from the line buffer outputs (rows 0..K-2) and in_pixel (row K-1).
  - The line buffers advance one position.
  - col increments; on col==ROW_SIZE-1 it wraps to 0 and row increments.
- State machine:
  - IDLE: in_ready=1. Accepted pixels without in_sof are dropped. An accept with in_sof is treated as pixel (0,0) and goes to FILL.
  - FILL: row < KERNEL_DIM-1; no windows are emitted. Moves to STREAM when row reaches KERNEL_DIM-1.
  - STREAM: on an accept at col >= KERNEL_DIM-1, out_valid is set the next cycle (1-cycle latency) with the completed window. out_last=1 if that pixel is (FRAME_ROWS-1, ROW_SIZE-1). Accepting that last pixel returns the state to IDLE.
- Output count per frame: (FRAME_ROWS-K+1)*(ROW_SIZE-K+1). No window may straddle a row boundary: columns < K-1 emit nothing.
- in_sof while in FILL/STREAM: the frame restarts. That pixel becomes (0,0), counters reset, state=FILL.
- An already-registered output window stays valid until transferred.
- out_valid clears after a transfer unless a new window is loaded in the same cycle. Back-to-back transfer plus load is allowed at 1 window per cycle.
- No arithmetic on pixel values. Counters are sized $clog2(ROW_SIZE) and $clog2(FRAME_ROWS) bits.

Decomposition:
- Package max_pool_pkg holds:
  - DATA_WIDTH, KERNEL_DIM, ROW_SIZE, FRAME_ROWS defaults.
  - pixel_t typedef.
  - window_t typedef (packed KERNEL_DIM x KERNEL_DIM array of pixel_t), shared with the max-pool stage.
  - State enum {IDLE, FILL, STREAM}.
- Sub-module line_buffer (DATA_WIDTH, DEPTH=ROW_SIZE):
  - Enable-gated delay line, output = input from DEPTH accepts ago.
  - Instantiated KERNEL_DIM-1 times and cascaded.
  - Inferable as a circular-pointer RAM.

Test Plan:
(Use ROW_SIZE=5, FRAME_ROWS=4, KERNEL_DIM=3; pixel value = 5*r+c.)
- Basic frame:
  - Stimulus: stream 20 pixels with in_sof on the first, out_ready=1.
  - Required: exactly 6 windows. First window appears 1 cycle after accepting pixel 12, rows {0,1,2},{5,6,7},{10,11,12}. Last window is {7,8,9},{12,13,14},{17,18,19} with out_last=1; out_last=0 on the others.
- Backpressure:
  - Stimulus: as above, out_ready=0 for 4 cycles after the first out_valid.
  - Required: in_ready=0 and out_window held at the first window throughout; no pixel lost; the remaining 5 windows are bit-exact.
- Pre-sof garbage:
  - Stimulus: 7 pixels (value 99) without in_sof, then the basic frame.
  - Required: output identical to the basic-frame case.
- Mid-frame restart:
  - Stimulus: in_sof asserted on pixel 8 of a frame, followed by a full fresh frame.
  - Required: no window from the aborted frame; 6 correct windows from the new frame.
- Async reset:
  - Stimulus: assert rst between clock edges while out_valid=1.
  - Required: out_valid=0 and out_last=0 immediately (before the next edge); a following frame produces 6 correct windows.
- Back-to-back frames:
  - Stimulus: frame 2 starts the cycle after frame 1's last pixel, gapless in_valid.
  - Required: 12 windows total, out_last twice.
